// File: rtl/mfe_window_sched.sv
// mfe_window_sched: raster-scan scheduler for the median filter.
// For each pixel it fetches the zero-padded 3x3 neighbourhood from image
// memory, offers the window to the median unit, waits for the result and
// writes it to result memory.
module mfe_window_sched #(
    parameter int IMG_LOG2 = 7,
    parameter int AW       = 2 * IMG_LOG2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    output logic          busy,
    output logic [AW-1:0] iaddr,
    input  logic [7:0]    idata,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [71:0]   win_data,
    input  logic          med_valid,
    input  logic [7:0]    med_data,
    output logic [AW-1:0] addr,
    output logic [7:0]    data_wr,
    output logic          wen,
    output logic          done
);

    localparam int N  = IMG_LOG2;
    localparam int CW = IMG_LOG2 + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_OFFER,
        S_WAIT,
        S_WRITE
    } state_t;

    // Returns {in_range, address} of tap k around pixel (px,py). The
    // two extra coordinate bits catch both -1 and 2^N as out of range.
    function automatic logic [AW:0] tap_info(input logic [N-1:0] px,
                                             input logic [N-1:0] py,
                                             input logic [3:0]   k);
        logic [3:0]    col;
        logic [3:0]    row;
        logic [CW-1:0] sx;
        logic [CW-1:0] sy;
        logic          inr;
        col = k % 4'd3;
        row = k / 4'd3;
        sx  = {2'b00, px} + CW'(col) - CW'(1);
        sy  = {2'b00, py} + CW'(row) - CW'(1);
        inr = (sx[CW-1:N] == 2'b00) && (sy[CW-1:N] == 2'b00);
        return {inr, sy[N-1:0], sx[N-1:0]};
    endfunction

    state_t        r_state;
    logic [N-1:0]  r_x;
    logic [N-1:0]  r_y;
    logic [3:0]    r_cnt;
    logic          r_inr_cur;   // range flag of the tap addressed this cycle
    logic          r_inr_d;     // range flag of the tap whose data arrives now
    logic          r_busy;
    logic [AW-1:0] r_iaddr;
    logic          r_win_valid;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_data_wr;
    logic          r_wen;
    logic          r_done;

    logic [AW:0]   w_idle_info;
    logic [AW:0]   w_fetch_info;
    logic [AW:0]   w_start_info;
    logic [N-1:0]  w_nx;
    logic [N-1:0]  w_ny;
    logic          w_x_last;
    logic          w_y_last;

    assign w_x_last     = &r_x;
    assign w_y_last     = &r_y;
    assign w_nx         = r_x + N'(1);
    assign w_ny         = w_x_last ? r_y + N'(1) : r_y;
    assign w_idle_info  = tap_info(r_x, r_y, 4'd0);
    assign w_fetch_info = tap_info(r_x, r_y, r_cnt + 4'd1);
    assign w_start_info = tap_info(w_nx, w_ny, 4'd0);

    // Scan sequencing: fetch, offer, wait for median, write, advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_cnt       <= 4'd0;
            r_inr_cur   <= 1'b0;
            r_inr_d     <= 1'b0;
            r_busy      <= 1'b0;
            r_iaddr     <= '0;
            r_win_valid <= 1'b0;
            r_addr      <= '0;
            r_data_wr   <= 8'd0;
            r_wen       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_wen   <= 1'b0;
            r_done  <= 1'b0;
            r_inr_d <= r_inr_cur;
            case (r_state)
                S_IDLE: begin
                    // The done cycle itself does not accept a new start.
                    if (ready && !r_done) begin
                        r_busy    <= 1'b1;
                        r_state   <= S_FETCH;
                        r_cnt     <= 4'd0;
                        r_inr_cur <= w_idle_info[AW];
                        if (w_idle_info[AW]) begin
                            r_iaddr <= w_idle_info[AW-1:0];
                        end
                    end
                end
                S_FETCH: begin
                    if (r_cnt == 4'd9) begin
                        r_state     <= S_OFFER;
                        r_win_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt < 4'd8) begin
                            r_inr_cur <= w_fetch_info[AW];
                            if (w_fetch_info[AW]) begin
                                r_iaddr <= w_fetch_info[AW-1:0];
                            end
                        end
                    end
                end
                S_OFFER: begin
                    if (win_ready) begin
                        r_win_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (med_valid) begin
                        r_state   <= S_WRITE;
                        r_wen     <= 1'b1;
                        r_addr    <= {r_y, r_x};
                        r_data_wr <= med_data;
                    end
                end
                S_WRITE: begin
                    r_x <= w_nx;
                    r_y <= w_ny;
                    if (w_x_last && w_y_last) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state   <= S_FETCH;
                        r_cnt     <= 4'd0;
                        r_inr_cur <= w_start_info[AW];
                        if (w_start_info[AW]) begin
                            r_iaddr <= w_start_info[AW-1:0];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Window taps: tap gi is captured one cycle after its address was driven.
    for (genvar gi = 0; gi < 9; gi++) begin : g_tap
        logic [7:0] r_tap;
        // Capture idata, or zero for padding, into this tap.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_tap <= 8'd0;
            end else if (r_state == S_FETCH && r_cnt == 4'(gi + 1)) begin
                r_tap <= r_inr_d ? idata : 8'd0;
            end
        end
        assign win_data[8*gi +: 8] = r_tap;
    end

    assign busy      = r_busy;
    assign iaddr     = r_iaddr;
    assign win_valid = r_win_valid;
    assign addr      = r_addr;
    assign data_wr   = r_data_wr;
    assign wen       = r_wen;
    assign done      = r_done;

endmodule

// File: tb/tb_mfe_window_sched.sv
// Testbench for mfe_window_sched on an 8x8 image with random pixel data.
module tb_mfe_window_sched;

    localparam int N  = 3;
    localparam int S  = 1 << N;
    localparam int AW = 2 * N;

    logic          clk;
    logic          reset;
    logic          ready;
    logic          busy;
    logic [AW-1:0] iaddr;
    logic [7:0]    idata;
    logic          win_valid;
    logic          win_ready;
    logic [71:0]   win_data;
    logic          med_valid;
    logic [7:0]    med_data;
    logic [AW-1:0] addr;
    logic [7:0]    data_wr;
    logic          wen;
    logic          done;

    mfe_window_sched #(.IMG_LOG2(N), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ready     (ready),
        .busy      (busy),
        .iaddr     (iaddr),
        .idata     (idata),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .med_valid (med_valid),
        .med_data  (med_data),
        .addr      (addr),
        .data_wr   (data_wr),
        .wen       (wen),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] img [0:S*S-1];

    // Synchronous-read image memory: data valid the cycle after the address.
    always @(posedge clk) idata <= img[iaddr];

    int            checks   = 0;
    int            failures = 0;
    int            cur_x    = 0;
    int            cur_y    = 0;
    logic [AW-1:0] prev_ia  = '0;
    logic [AW-1:0] last_wa  = '0;
    logic [7:0]    last_wd  = 8'd0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s pixel=(%0d,%0d) observed=%0h expected=%0h", tag, cur_x, cur_y, obs, exp);
        end
    endtask

    task automatic tick();
        prev_ia = iaddr;
        @(posedge clk);
        #1;
    endtask

    // Reference: address of tap k around (px,py), or -1 when it falls outside.
    function automatic int tap_addr(input int px, input int py, input int k);
        int xx;
        int yy;
        xx = px + (k % 3) - 1;
        yy = py + (k / 3) - 1;
        if (xx < 0 || yy < 0 || xx >= S || yy >= S) return -1;
        return yy * S + xx;
    endfunction

    function automatic logic [71:0] exp_win(input int px, input int py);
        logic [71:0] w;
        int a;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            a = tap_addr(px, py, k);
            w[8*k +: 8] = (a < 0) ? 8'd0 : img[a];
        end
        return w;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},      busy,      1'b0);
        chk({tag, "_iaddr"},     iaddr,     '0);
        chk({tag, "_win_valid"}, win_valid, 1'b0);
        chk({tag, "_win_data"},  win_data,  '0);
        chk({tag, "_addr"},      addr,      '0);
        chk({tag, "_data_wr"},   data_wr,   8'd0);
        chk({tag, "_wen"},       wen,       1'b0);
        chk({tag, "_done"},      done,      1'b0);
    endtask

    // Process one pixel, entered in FETCH cycle 0 and left one cycle after WRITE.
    task automatic do_pixel(input int px, input int py, input int hold,
                            input int medlat, input bit inject, input bit last);
        logic [71:0] w_exp;
        logic [7:0]  m;
        int a;
        cur_x = px;
        cur_y = py;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) begin
                a = tap_addr(px, py, i);
                if (a >= 0) chk("fetch_iaddr", iaddr, a);
                else        chk("fetch_iaddr_hold", iaddr, prev_ia);
            end
            chk("fetch_win_valid", win_valid, 1'b0);
            chk("fetch_wen", wen, 1'b0);
            if (inject && i == 4) begin
                med_valid = 1'b1;
                med_data  = 8'($urandom);
            end
            tick();
            med_valid = 1'b0;
        end
        w_exp = exp_win(px, py);
        chk("offer_win_valid", win_valid, 1'b1);
        chk("offer_win_data", win_data, w_exp);
        chk("offer_busy", busy, 1'b1);
        for (int h = 0; h < hold; h++) begin
            win_ready = 1'b0;
            tick();
            chk("stall_win_valid", win_valid, 1'b1);
            chk("stall_win_data", win_data, w_exp);
        end
        win_ready = 1'b1;
        tick();
        win_ready = 1'b0;
        chk("wait_win_valid", win_valid, 1'b0);
        for (int l = 0; l < medlat; l++) begin
            chk("wait_wen", wen, 1'b0);
            chk("wait_addr_hold", addr, last_wa);
            chk("wait_data_hold", data_wr, last_wd);
            tick();
            chk("wait_win_valid", win_valid, 1'b0);
        end
        chk("wait_wen", wen, 1'b0);
        m = (px % 2 == 0) ? w_exp[39:32] : 8'($urandom);
        med_valid = 1'b1;
        med_data  = m;
        tick();
        med_valid = 1'b0;
        med_data  = 8'($urandom);
        chk("write_wen", wen, 1'b1);
        chk("write_addr", addr, py * S + px);
        chk("write_data", data_wr, m);
        last_wa = addr;
        last_wd = data_wr;
        $display("pixel (%0d,%0d) addr=%0d window=%h median=%02h", px, py, py * S + px, w_exp, m);
        tick();
        chk("post_write_wen", wen, 1'b0);
        chk("post_write_done", done, last);
        chk("post_write_busy", busy, !last);
    endtask

    initial begin
        reset     = 1'b1;
        ready     = 1'b0;
        win_ready = 1'b0;
        med_valid = 1'b0;
        med_data  = 8'd0;
        for (int i = 0; i < S * S; i++) img[i] = 8'($urandom);

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_busy", busy, 1'b0);
        end

        // Full frame with varied stall / latency and stray med_valid pulses.
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("start_busy", busy, 1'b1);
        for (int p = 0; p < S * S; p++) begin
            ready = (p == S * S - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            do_pixel(p % S, p / S,
                     (p == 0) ? 5 : int'($urandom_range(0, 2)),
                     (p == 0) ? 3 : int'($urandom_range(0, 3)),
                     (p % 5 == 1), (p == S * S - 1));
        end
        ready = 1'b0;
        tick();
        chk("done_pulse_end", done, 1'b0);
        chk("idle_after_frame_busy", busy, 1'b0);

        // Second frame, aborted by reset during FETCH cycle 5 of pixel (3,0).
        ready = 1'b1;
        tick();
        ready = 1'b0;
        for (int p = 0; p < 3; p++) do_pixel(p, 0, 0, 1, 1'b0, 1'b0);
        cur_x = 3;
        cur_y = 0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("abort");
        last_wa = '0;
        last_wd = 8'd0;
        reset = 1'b0;
        tick();
        chk("post_abort_busy", busy, 1'b0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        do_pixel(0, 0, 2, 1, 1'b1, 1'b0);
        do_pixel(1, 0, 0, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mfe_window_sched.md
Name: mfe_window_sched

Overview:
- Raster-scan scheduler for the median-filter datapath.
- Walks every pixel of a square grayscale image and fetches its 3x3 neighbourhood from the image memory, zero-padding outside the frame.
- Hands the 9-pixel window to an external median unit over a valid/ready handshake, then writes the returned median to the result memory.
- Owns the image-memory read port and the result-memory write port. The median unit is pure datapath and contains no sequencing.

Parameters:
- IMG_LOG2, 7, log2 of image side; image is 2^IMG_LOG2 x 2^IMG_LOG2 pixels (128x128 default).
- AW, 2*IMG_LOG2, memory address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- ready  in  1  host start request, level-sampled in IDLE
- busy  out  1  high from frame start until the last result is written
- iaddr  out  AW  image memory read address
- idata  in  8  image read data, valid the cycle after iaddr
- win_valid  out  1  window available to median unit
- win_ready  in  1  median unit accepts the window
- win_data  out  72  taps 0..8; tap k in bits [8k+7:8k]
- med_valid  in  1  median result strobe, one cycle
- med_data  in  8  median value
- addr  out  AW  result memory write address
- data_wr  out  8  result write data
- wen  out  1  result write enable, one-cycle pulse
- done  out  1  one-cycle pulse after the final write

Behaviour:
- Reset (async, high): state=IDLE, x=y=0, busy=0, iaddr=0, win_valid=0, win_data=0, addr=0, data_wr=0, wen=0, done=0.
- Reset asserted mid-frame aborts immediately; no partial write is issued.
- Addressing: pixel (x,y) maps to {y,x} (row-major, x fastest).
- Tap k: dx = k%3-1, dy = k/3-1. Coordinates are computed with IMG_LOG2+2-bit signed arithmetic.
- A tap is out of range if x+dx or y+dy is <0 or >=2^IMG_LOG2. An out-of-range tap reads as 0.
- IDLE: busy=0. On ready=1, next cycle busy=1 and state=FETCH with x=y=0. ready is ignored while busy=1.
- FETCH: 10 cycles.
  - Cycle i (0..8) drives iaddr for tap i if in range; otherwise iaddr holds its value.
  - Cycle i+1 captures idata, or 0 if tap i is out of range, into tap i of the window register.
  - A per-tap range flag is pipelined one stage so capture uses the flag of the tap being captured.
  - After cycle 9, state=OFFER.
- OFFER: win_valid=1. win_data is stable and must not change while win_valid=1 && !win_ready.
  - Transfer occurs when win_valid && win_ready. Next cycle win_valid=0 and state=WAIT.
- WAIT: hold until med_valid=1. Latch med_data and go to WRITE.
  - med_valid in any other state is ignored.
- WRITE: one cycle with wen=1, addr={y,x}, data_wr=median. Then advance the scan:
  - If x != max: x+1.
  - Else if y != max: x=0, y+1.
  - Else (last pixel): done=1 for the next cycle, busy=0, state=IDLE.
  - Otherwise state=FETCH.
- wen is 0 in all states except WRITE. addr and data_wr hold their values between writes.
- Minimum per-pixel latency: 10 (FETCH) + 1 (OFFER with win_ready=1) + WAIT + 1 (WRITE) cycles.
- Frame wrap: after the last pixel, x=y=0 so a new ready starts a fresh frame.
- done and a new ready in the same cycle: IDLE samples ready on the following cycle; no overlap.

Test Plan:
- IMG_LOG2=7, pixel (0,0), idata = low byte of iaddr -> exactly 4 reads at iaddr 0,1,128,129; taps 0,1,2,3,6 = 0; taps 4,5,7,8 = 0x00,0x01,0x80,0x81.
- Pixel (127,127) -> reads only 16254,16255,16382,16383; taps 2,5,6,7,8 = 0.
- Hold win_ready=0 for 5 cycles in OFFER -> win_valid stays 1, win_data unchanged; on win_ready=1 one transfer, no duplicate.
- IMG_LOG2=2 (4x4), median unit returns tap 4 after 3 cycles -> 16 wen pulses at addr 0..15 in order, data_wr = center pixel, one done pulse, busy falls with it.
- Assert reset during FETCH cycle 5 of pixel (3,0) -> all outputs at reset values next edge; after release and ready=1, scan restarts at (0,0).
- Pulse med_valid while in FETCH -> ignored; no wen issued.
